// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: FSM states, load funct3 encodings, alignment helper.
// WB_MISALIGN_CHECK_EN adds the FAULT state for misaligned halfword/word loads.
package wb_pkg;

`ifdef WB_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, ALU, WAIT, HELD, FAULT} wb_state_t;
`else
  typedef enum logic [2:0] {IDLE, ALU, WAIT, HELD} wb_state_t;
`endif

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic misaligned_access(input logic [2:0] funct3, input logic [1:0] addr);
    return (((funct3 == F3_LH) || (funct3 == F3_LHU)) && addr[0]) ||
           ((funct3 == F3_LW) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load lane extraction with sign/zero extension from a word-aligned response.
module load_aligner
  import wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    // Undefined widths fall back to the full word
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'b0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'b0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: holds the retiring instruction, waits for load data, drives the regfile write port.
// Optional WB_MISALIGN_CHECK_EN adds the misaligned output and FAULT state.
module writeback_stage
  import wb_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
`ifdef WB_MISALIGN_CHECK_EN
  output logic        misaligned,
`endif
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_we,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_result,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        stall,
  output logic [31:0] regfile_data_in,
  output logic [4:0]  regfile_destination,
  output logic        regfile_we
);

  wb_state_t   state_p1, state_d;
  logic [4:0]  rd_p1;
  logic        rd_we_p1;
  logic [2:0]  funct3_p1;
  logic [31:0] result_p1;
  logic [31:0] hold_p1;
  logic [31:0] extracted;
  logic        latch_hold;
  logic        capture;
  logic        rd_we_eff;

  load_aligner u_aligner (
    .rdata  (dmem_rdata),
    .addr   (result_p1[1:0]),
    .funct3 (funct3_p1),
    .result (extracted)
  );

  assign rd_we_eff           = rd_we_p1 && (rd_p1 != 5'd0) && !(RV32E && rd_p1[4]);
  assign regfile_destination = rd_p1;
  assign capture             = clk_en && !stall;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) state_p1 <= IDLE;
    else              state_p1 <= state_d;
  end

  always_comb begin
    state_d         = state_p1;
    stall           = 1'b0;
    regfile_we      = 1'b0;
    regfile_data_in = '0;
    latch_hold      = 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
    misaligned      = 1'b0;
`endif
    case (state_p1)
      ALU: begin
        regfile_we      = rd_we_eff;
        regfile_data_in = result_p1;
      end
      WAIT: begin
        stall           = !dmem_rvalid;
        regfile_data_in = extracted;
        // Response with the pipeline frozen is parked so it is not lost
        if (dmem_rvalid) begin
          if (clk_en) begin
            regfile_we = rd_we_eff;
          end else begin
            latch_hold = 1'b1;
            state_d    = HELD;
          end
        end
      end
      HELD: begin
        regfile_we      = rd_we_eff;
        regfile_data_in = hold_p1;
      end
`ifdef WB_MISALIGN_CHECK_EN
      FAULT: misaligned = 1'b1;
`endif
      default: ;
    endcase

    if (clk_en && !stall) begin
      if (!ex_valid)        state_d = IDLE;
      else if (!ex_is_load) state_d = ALU;
`ifdef WB_MISALIGN_CHECK_EN
      else if (misaligned_access(ex_funct3, ex_result[1:0])) state_d = FAULT;
`endif
      else                  state_d = WAIT;
    end
  end

  // Stage register: capture from execute
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rd_p1     <= '0;
      rd_we_p1  <= 1'b0;
      funct3_p1 <= '0;
      result_p1 <= '0;
      hold_p1   <= '0;
    end else begin
      if (capture) begin
        rd_p1     <= ex_rd;
        rd_we_p1  <= ex_rd_we;
        funct3_p1 <= ex_funct3;
        result_p1 <= ex_result;
      end
      if (latch_hold) hold_p1 <= extracted;
    end
  end

endmodule
